// File: rtl/rom_bank.sv
// rom_bank: synchronous-read program memory with an instruction-fetch port,
// a data-read port and an in-system loader. The loader streams a new image
// into the memory and then zero-fills the unused tail.
module rom_bank #(
    parameter int DEPTH         = 1024,
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 31,
    parameter bit FETCH_HOLD_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        if_addr,
    input  logic                     if_hold,
    output logic [DATA_W-1:0]        if_data,
    output logic                     if_fault,
    input  logic [ADDR_W-1:0]        dr_addr,
    input  logic                     dr_en,
    output logic [DATA_W-1:0]        dr_data,
    output logic                     dr_valid,
    output logic                     dr_fault,
    input  logic                     ld_start,
    input  logic                     ld_valid,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic                     ld_last,
    output logic                     ld_ready,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   ld_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_PTR = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t                state;
    // One bit wider than the word index so a full image shows up as ptr == DEPTH.
    logic [CNT_W-1:0]      ptr;

    logic [DATA_W-1:0]     mem [DEPTH];

    logic [IDX_W-1:0]      if_idx;
    logic [IDX_W-1:0]      dr_idx;
    logic                  if_oor;
    logic                  dr_oor;
    logic                  dr_bad;
    logic                  xfer;

    logic                  we;
    logic [IDX_W-1:0]      waddr;
    logic [DATA_W-1:0]     wdata;

    // The fetch port works on whole words; the byte offset is deliberately dropped.
    logic                  unused_if_lsb;
    assign unused_if_lsb = &{1'b0, if_addr[1:0]};

    assign if_idx = if_addr[IDX_W+1:2];
    assign dr_idx = dr_addr[IDX_W+1:2];
    assign if_oor = |if_addr[ADDR_W-1:IDX_W+2];
    assign dr_oor = |dr_addr[ADDR_W-1:IDX_W+2];
    assign dr_bad = dr_oor | (|dr_addr[1:0]);
    assign xfer   = (state == LOAD) && ld_valid && ld_ready;

    // Single write port: loader words during LOAD, zeros during CLEAR.
    always_comb begin
        we    = 1'b0;
        waddr = ptr[IDX_W-1:0];
        wdata = '0;
        if (xfer) begin
            we    = 1'b1;
            wdata = ld_data;
        end else if ((state == CLEAR) && !ptr[IDX_W]) begin
            we    = 1'b1;
        end
    end

    // Memory array; never reset so configuration-time contents survive.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Loader FSM: RUN -> LOAD on ld_start, LOAD -> CLEAR on the last word, CLEAR -> RUN at the top.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            ptr      <= '0;
            busy     <= 1'b0;
            ld_ready <= 1'b0;
            ld_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ld_start) begin
                        state    <= LOAD;
                        ptr      <= '0;
                        busy     <= 1'b1;
                        ld_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        ptr <= ptr + 1'b1;
                        if (ld_last || (ptr == LAST_PTR)) begin
                            ld_count <= ptr + 1'b1;
                            state    <= CLEAR;
                            ld_ready <= 1'b0;
                        end
                    end
                end
                CLEAR: begin
                    // A wrapped pointer means the image filled memory: nothing to clear.
                    if (ptr[IDX_W] || (ptr == LAST_PTR)) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state    <= RUN;
                    busy     <= 1'b0;
                    ld_ready <= 1'b0;
                end
            endcase
        end
    end

    // Fetch port: NOPs while busy, optional stall hold, zero data on out-of-range.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_data  <= '0;
            if_fault <= 1'b0;
        end else if (state != RUN) begin
            if_data  <= '0;
            if_fault <= 1'b0;
        end else if (!(FETCH_HOLD_EN && if_hold)) begin
            if_fault <= if_oor;
            if_data  <= if_oor ? '0 : mem[if_idx];
        end
    end

    // Data port: valid tracks the request, data held when idle, zero on fault or while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dr_valid <= 1'b0;
            dr_fault <= 1'b0;
            dr_data  <= '0;
        end else begin
            dr_valid <= dr_en;
            if (state != RUN) begin
                dr_fault <= 1'b0;
                dr_data  <= '0;
            end else if (dr_en) begin
                dr_fault <= dr_bad;
                dr_data  <= dr_bad ? '0 : mem[dr_idx];
            end else begin
                dr_fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rom_bank.sv
// Testbench for rom_bank: directed stimulus, expectations queued per cycle
// and per data-port response, checked by a separate monitor.
module tb_rom_bank;

    localparam int DEPTH  = 1024;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 31;

    localparam int K_IFD  = 0;
    localparam int K_IFF  = 1;
    localparam int K_DRD  = 2;
    localparam int K_DRV  = 3;
    localparam int K_DRF  = 4;
    localparam int K_RDY  = 5;
    localparam int K_BUSY = 6;
    localparam int K_CNT  = 7;
    localparam int K_BLEN = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [ADDR_W-1:0]  if_addr;
    logic               if_hold;
    logic [DATA_W-1:0]  if_data;
    logic               if_fault;
    logic [ADDR_W-1:0]  dr_addr;
    logic               dr_en;
    logic [DATA_W-1:0]  dr_data;
    logic               dr_valid;
    logic               dr_fault;
    logic               ld_start;
    logic               ld_valid;
    logic [DATA_W-1:0]  ld_data;
    logic               ld_last;
    logic               ld_ready;
    logic               busy;
    logic [10:0]        ld_count;

    rom_bank #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FETCH_HOLD_EN(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .if_addr(if_addr), .if_hold(if_hold), .if_data(if_data), .if_fault(if_fault),
        .dr_addr(dr_addr), .dr_en(dr_en), .dr_data(dr_data), .dr_valid(dr_valid),
        .dr_fault(dr_fault),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .busy(busy), .ld_count(ld_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic        fault;
    } drexp_t;

    exp_t   expq[$];
    drexp_t drq[$];

    int cyc         = 0;
    int checks      = 0;
    int errors      = 0;
    int busy_cycles = 0;
    int busy_len    = 0;
    bit fin_req     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] img(input int i);
        return (i == 3) ? 32'h3C10_4000 : (32'h1000_0000 + 32'(i));
    endfunction

    function automatic string kname(input int k);
        case (k)
            K_IFD:   return "if_data";
            K_IFF:   return "if_fault";
            K_DRD:   return "dr_data";
            K_DRV:   return "dr_valid";
            K_DRF:   return "dr_fault";
            K_RDY:   return "ld_ready";
            K_BUSY:  return "busy";
            K_CNT:   return "ld_count";
            K_BLEN:  return "busy_length";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_IFD:   return if_data;
            K_IFF:   return {31'b0, if_fault};
            K_DRD:   return dr_data;
            K_DRV:   return {31'b0, dr_valid};
            K_DRF:   return {31'b0, dr_fault};
            K_RDY:   return {31'b0, ld_ready};
            K_BUSY:  return {31'b0, busy};
            K_CNT:   return {21'b0, ld_count};
            K_BLEN:  return 32'(busy_len);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Monitor: compares cycle-tagged expectations and every data-port response.
    exp_t        m_e;
    drexp_t      m_d;
    logic [31:0] m_act;
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cycles++;
        while (expq.size() > 0 && expq[0].cyc <= cyc) begin
            m_e   = expq.pop_front();
            m_act = actual(m_e.kind);
            checks++;
            if (m_act !== m_e.val) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h want=%h", kname(m_e.kind), cyc, m_act, m_e.val);
            end
        end
        if (dr_valid === 1'b1) begin
            checks++;
            if (drq.size() == 0) begin
                errors++;
                $display("FAIL dr_unexpected cyc=%0d got valid=1 want no response", cyc);
            end else begin
                m_d = drq.pop_front();
                if (dr_data !== m_d.data || dr_fault !== m_d.fault) begin
                    errors++;
                    $display("FAIL dr_resp cyc=%0d got data=%h fault=%b want data=%h fault=%b",
                             cyc, dr_data, dr_fault, m_d.data, m_d.fault);
                end
            end
        end
        if (fin_req) begin
            checks++;
            if (expq.size() != 0 || drq.size() != 0) begin
                errors++;
                $display("FAIL leftover got pending=%0d/%0d want 0/0", expq.size(), drq.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_at(input int dc, input int k, input logic [31:0] v);
        expq.push_back('{cyc + dc, k, v});
    endtask

    task automatic dr_req(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic f);
        dr_en   = 1'b1;
        dr_addr = a;
        drq.push_back('{d, f});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        if_addr  = '0;
        if_hold  = 1'b0;
        dr_addr  = '0;
        dr_en    = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;

        // Reset state: every output low while reset is held.
        tick(); tick();
        exp_at(1, K_IFD, 0);  exp_at(1, K_IFF, 0);  exp_at(1, K_DRD, 0);
        exp_at(1, K_DRV, 0);  exp_at(1, K_DRF, 0);  exp_at(1, K_RDY, 0);
        exp_at(1, K_BUSY, 0); exp_at(1, K_CNT, 0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Full-depth image without ld_last: CLEAR is a single pass-through cycle.
        ld_start = 1'b1;
        exp_at(1, K_BUSY, 1); exp_at(1, K_RDY, 1);
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_valid = 1'b1;
            ld_data  = img(i);
            tick();
        end
        ld_valid = 1'b0;
        exp_at(0, K_BUSY, 1); exp_at(0, K_RDY, 0); exp_at(0, K_CNT, DEPTH);
        exp_at(1, K_BUSY, 0);
        tick(); tick();

        // Fetch after the image is in place.
        if_addr = 31'h0C;
        exp_at(1, K_IFD, 32'h3C10_4000); exp_at(1, K_IFF, 0);
        tick();

        // Hold and out-of-range fetch.
        if_addr = 31'h10;
        exp_at(1, K_IFD, img(4));
        tick();
        if_hold = 1'b1; if_addr = 31'h14;
        exp_at(1, K_IFD, img(4));
        tick();
        if_hold = 1'b0; if_addr = 31'h1000;
        exp_at(1, K_IFD, 0); exp_at(1, K_IFF, 1);
        tick();
        if_hold = 1'b1; if_addr = 31'h0;
        exp_at(1, K_IFF, 1);
        tick();
        if_hold = 1'b0;

        // Data port: misaligned, out of range, good, then idle hold.
        dr_req(31'h0E, 32'h0, 1'b1);         tick();
        dr_req(31'h1000, 32'h0, 1'b1);       tick();
        dr_req(31'h08, img(2), 1'b0);        tick();
        dr_en = 1'b0;
        exp_at(1, K_DRV, 0); exp_at(1, K_DRD, img(2));
        tick();
        exp_at(1, K_DRD, img(2));
        tick();

        // ld_start together with reads: reads see old contents, busy rises next edge.
        ld_start = 1'b1;
        if_addr  = 31'h0C;
        dr_req(31'h0C, 32'h3C10_4000, 1'b0);
        exp_at(1, K_IFD, 32'h3C10_4000); exp_at(1, K_BUSY, 1);
        tick();
        ld_start = 1'b0;
        dr_en    = 1'b0;
        exp_at(1, K_IFD, 0);
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hB0 + 32'(i);
            tick();
        end
        ld_valid = 1'b0;

        // Reset in the middle of a load: partial image kept, ld_count cleared.
        reset = 1'b0;
        #1;
        exp_at(0, K_BUSY, 0); exp_at(0, K_RDY, 0); exp_at(0, K_CNT, 0);
        tick();
        reset = 1'b1;
        tick();
        dr_req(31'h00, 32'hB0, 1'b0);        tick();
        dr_req(31'h04, 32'hB1, 1'b0);        tick();
        dr_req(31'h08, 32'hB2, 1'b0);        tick();
        dr_req(31'h0C, 32'h3C10_4000, 1'b0); tick();
        dr_en = 1'b0;
        if_addr = 31'h10;
        exp_at(1, K_IFD, img(4));
        tick();

        // Short load with gaps, then a tail clear of DEPTH-5 words.
        busy_len = busy_cycles;
        ld_start = 1'b1;
        exp_at(1, K_BUSY, 1);
        tick();
        ld_start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            ld_valid = (k % 2 == 0);
            ld_data  = (k % 2 == 0) ? (32'hA0 + 32'(k / 2)) : 32'hDEAD_BEEF;
            ld_last  = (k == 8);
            ld_start = (k == 1);
            if (k == 3) begin
                if_addr = 31'h0C;
                dr_req(31'h0C, 32'h0, 1'b0);
                exp_at(1, K_IFD, 0); exp_at(1, K_IFF, 0);
            end else begin
                dr_en = 1'b0;
            end
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0; dr_en = 1'b0;
        exp_at(0, K_CNT, 5); exp_at(0, K_RDY, 0);
        for (int n = 0; n < 3000 && busy; n++) tick();
        exp_at(0, K_BUSY, 0);
        busy_len = busy_cycles - busy_len;
        exp_at(0, K_BLEN, 9 + 1019);
        tick();

        // Contents after the short load.
        dr_req(31'h00, 32'hA0, 1'b0);        tick();
        dr_req(31'h04, 32'hA1, 1'b0);        tick();
        dr_req(31'h0C, 32'hA3, 1'b0);        tick();
        dr_req(31'h10, 32'hA4, 1'b0);        tick();
        dr_req(31'h14, 32'h0, 1'b0);         tick();
        dr_req(31'h800, 32'h0, 1'b0);        tick();
        dr_req(31'hFFC, 32'h0, 1'b0);        tick();
        dr_en = 1'b0;
        if_addr = 31'h10;
        exp_at(1, K_IFD, 32'hA4);
        tick();
        if_addr = 31'hFFC;
        exp_at(1, K_IFD, 0); exp_at(1, K_IFF, 0);
        tick();

        tick(); tick();
        fin_req = 1'b1;
    end

endmodule
